// File: rtl/apb_bridge_pkg.sv
// Shared types and default parameter values for the APB-to-APB bridge.
package apb_bridge_pkg;

   localparam int SLOT_W      = 4;
   localparam int NSLOT_DEF   = 16;
   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int SEL_LSB_DEF = 24;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } bridge_state_e;

endpackage

// File: rtl/apb_slot_decode.sv
// Slot index to one-hot downstream select; flags indices at or above NSLOT.
module apb_slot_decode
   import apb_bridge_pkg::*;
#(
   parameter int NSLOT = NSLOT_DEF
)(
   input  logic [SLOT_W-1:0] slot,
   output logic [NSLOT-1:0]  sel_onehot,
   output logic              unmapped
);

   always_comb begin
      sel_onehot = '0;
      unmapped   = 1'b1;
      for (int i = 0; i < NSLOT; i++) begin
         if (slot == SLOT_W'(i)) begin
            sel_onehot[i] = 1'b1;
            unmapped      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/apb2apb_bridge.sv
// Single-clock APB-to-APB bridge fanning one upstream port out to NSLOT slots.
// Optional access-phase timeout enabled by defining APB2APB_BRIDGE_TIMEOUT_EN.
//
//   state     | meaning
//   ST_IDLE   | waiting for an upstream setup phase
//   ST_SETUP  | downstream setup phase, PSEL_S asserted
//   ST_ACCESS | downstream access phase, waiting for slot PREADY_S
//   ST_RESP   | one-cycle upstream completion with latched data/error
module apb2apb_bridge
   import apb_bridge_pkg::*;
#(
   parameter int NSLOT   = NSLOT_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SEL_LSB = SEL_LSB_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL_M,
   input  logic                    PENABLE_M,
   input  logic [ADDR_W-1:0]       PADDR_M,
   input  logic                    PWRITE_M,
   input  logic [DATA_W-1:0]       PWDATA_M,
   output logic [DATA_W-1:0]       PRDATA_M,
   output logic                    PREADY_M,
   output logic                    PSLVERR_M,
   output logic [NSLOT-1:0]        PSEL_S,
   output logic                    PENABLE_S,
   output logic                    PWRITE_S,
   output logic [ADDR_W-1:0]       PADDR_S,
   output logic [DATA_W-1:0]       PWDATA_S,
   input  logic [NSLOT*DATA_W-1:0] PRDATA_S,
   input  logic [NSLOT-1:0]        PREADY_S,
   input  logic [NSLOT-1:0]        PSLVERR_S
);

   if (NSLOT < 1 || NSLOT > 16) begin : g_bad_nslot
      $error("apb2apb_bridge: NSLOT must be 1..16");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("apb2apb_bridge: TIMEOUT must be 1..255");
   end
   if (SEL_LSB + SLOT_W > ADDR_W) begin : g_bad_sel_lsb
      $error("apb2apb_bridge: slot field exceeds ADDR_W");
   end

   bridge_state_e      state_q, state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q, rdata_q, rdata_sel;
   logic               write_q, err_q;
   logic [NSLOT-1:0]   sel_q, sel_dec;
   logic               unmapped, start, rdy_sel, err_sel, timeout_hit, dn_active;

   assign start = PSEL_M && !PENABLE_M;

   apb_slot_decode #(.NSLOT(NSLOT)) u_slot_decode (
      .slot       (PADDR_M[SEL_LSB +: SLOT_W]),
      .sel_onehot (sel_dec),
      .unmapped   (unmapped)
   );

   // Slot response muxing goes through the captured one-hot select, so no
   // out-of-range index is possible when NSLOT < 16.
   assign rdy_sel = |(PREADY_S & sel_q);
   assign err_sel = |(PSLVERR_S & sel_q);

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (sel_q[i]) rdata_sel = rdata_sel | PRDATA_S[i*DATA_W +: DATA_W];
      end
   end

`ifdef APB2APB_BRIDGE_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
   logic [7:0] cnt_q;

   always_ff @(posedge PCLK) begin
      if (PRESET)                      cnt_q <= '0;
      else if (state_q == ST_SETUP)    cnt_q <= '0;
      else if (state_q == ST_ACCESS)   cnt_q <= cnt_q + 8'd1;
      else                             cnt_q <= '0;
   end

   // cnt_q + 1 is the number of access cycles including the current one.
   assign timeout_hit = (state_q == ST_ACCESS) && !rdy_sel && (cnt_q + 8'd1 == TO_LIM);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = unmapped ? ST_RESP : ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (rdy_sel || timeout_hit) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= PADDR_M;
                  wdata_q <= PWDATA_M;
                  write_q <= PWRITE_M;
                  sel_q   <= unmapped ? '0 : sel_dec;
                  rdata_q <= '0;
                  err_q   <= unmapped;
               end
            end
            ST_ACCESS: begin
               if (rdy_sel) begin
                  rdata_q <= write_q ? '0 : rdata_sel;
                  err_q   <= err_sel;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            ST_RESP: begin
               addr_q  <= '0;
               wdata_q <= '0;
               write_q <= 1'b0;
               sel_q   <= '0;
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      dn_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
      PSEL_S    = dn_active ? sel_q : '0;
      PENABLE_S = (state_q == ST_ACCESS);
      PWRITE_S  = dn_active && write_q;
      PADDR_S   = dn_active ? addr_q : '0;
      PWDATA_S  = dn_active ? wdata_q : '0;
      PREADY_M  = (state_q == ST_RESP);
      PRDATA_M  = (state_q == ST_RESP) ? rdata_q : '0;
      PSLVERR_M = (state_q == ST_RESP) && err_q;
   end

endmodule

// File: tb/tb_apb2apb_bridge.sv
// Scoreboard bench for apb2apb_bridge with an 8-slot configuration.
module tb_apb2apb_bridge;

   localparam int NSLOT  = 8;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
`ifdef APB2APB_BRIDGE_TIMEOUT_EN
   localparam int TO = 10;
`else
   localparam int TO = 255;
`endif

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic                    PCLK = 1'b0;
   logic                    PRESET;
   logic                    PSEL_M, PENABLE_M, PWRITE_M;
   logic [ADDR_W-1:0]       PADDR_M;
   logic [DATA_W-1:0]       PWDATA_M;
   logic [DATA_W-1:0]       PRDATA_M;
   logic                    PREADY_M, PSLVERR_M;
   logic [NSLOT-1:0]        PSEL_S;
   logic                    PENABLE_S, PWRITE_S;
   logic [ADDR_W-1:0]       PADDR_S;
   logic [DATA_W-1:0]       PWDATA_S;
   logic [NSLOT*DATA_W-1:0] PRDATA_S;
   logic [NSLOT-1:0]        PREADY_S, PSLVERR_S;

   int    tests = 0;
   int    fails = 0;
   resp_t sb_q[$];

   logic  hang = 1'b0;
   int    wait_n = 0;
   int    acc_cnt = 0;

   apb2apb_bridge #(
      .NSLOT(NSLOT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_LSB(24), .TIMEOUT(TO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .PSEL_M(PSEL_M), .PENABLE_M(PENABLE_M), .PADDR_M(PADDR_M),
      .PWRITE_M(PWRITE_M), .PWDATA_M(PWDATA_M),
      .PRDATA_M(PRDATA_M), .PREADY_M(PREADY_M), .PSLVERR_M(PSLVERR_M),
      .PSEL_S(PSEL_S), .PENABLE_S(PENABLE_S), .PWRITE_S(PWRITE_S),
      .PADDR_S(PADDR_S), .PWDATA_S(PWDATA_S),
      .PRDATA_S(PRDATA_S), .PREADY_S(PREADY_S), .PSLVERR_S(PSLVERR_S)
   );

   always #5 PCLK = ~PCLK;

   // Slave model: ready after wait_n completed access cycles unless hung.
   always @(posedge PCLK) acc_cnt <= PENABLE_S ? acc_cnt + 1 : 0;
   assign PREADY_S = (!hang && acc_cnt >= wait_n) ? {NSLOT{1'b1}} : {NSLOT{1'b0}};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic all_idle();
      return (PSEL_S == '0) && !PENABLE_S && !PWRITE_S && (PADDR_S == '0) &&
             (PWDATA_S == '0) && (PRDATA_M == '0) && !PREADY_M && !PSLVERR_M;
   endfunction

   always @(negedge PCLK) begin
      if (!PRESET) begin
         chk("psel_onehot0", {63'd0, $onehot0(PSEL_S)}, 64'd1);
         if (PREADY_M) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pready", 64'd1, 64'd0);
            end else begin
               resp_t e;
               e = sb_q.pop_front();
               chk("prdata_m", {32'd0, PRDATA_M}, {32'd0, e.rdata});
               chk("pslverr_m", {63'd0, PSLVERR_M}, {63'd0, e.err});
            end
         end else begin
            chk("idle_resp_zero", {31'd0, PSLVERR_M, PRDATA_M}, 64'd0);
         end
      end
   end

   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int exp_lat, input logic [7:0] exp_sel, input int exp_acc,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
      int lat = 0;
      int acc = 0;
      logic [7:0] seen = '0;
      logic done = 1'b0;
      sb_q.push_back('{rdata: exp_rd, err: exp_err});
      @(negedge PCLK);
      PSEL_M = 1'b1; PENABLE_M = 1'b0; PADDR_M = addr; PWRITE_M = wr; PWDATA_M = wd;
      while (!done && lat < 2000) begin
         @(negedge PCLK);
         lat++;
         PENABLE_M = 1'b1;
         seen = seen | PSEL_S;
         if (PSEL_S != '0)
            chk("dn_addr_wr_wdata", {PADDR_S, PWDATA_S[30:0], PWRITE_S}, {addr, wd[30:0], wr});
         if (PENABLE_S) acc++;
         if (PREADY_M) done = 1'b1;
      end
      chk("completed", {63'd0, done}, 64'd1);
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("psel_seen", {56'd0, seen}, {56'd0, exp_sel});
      chk("access_cycles", 64'(acc), 64'(exp_acc));
      for (int h = 0; h <= hold; h++) begin
         @(negedge PCLK);
         chk("after_resp_idle", {63'd0, all_idle()}, 64'd1);
      end
      PSEL_M = 1'b0; PENABLE_M = 1'b0; PWRITE_M = 1'b0; PWDATA_M = '0; PADDR_M = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET = 1'b1; PSEL_M = 1'b0; PENABLE_M = 1'b0; PWRITE_M = 1'b0;
      PADDR_M = '0; PWDATA_M = '0; PSLVERR_S = '0;
      for (int i = 0; i < NSLOT; i++) PRDATA_S[i*DATA_W +: DATA_W] = 32'hC0DE_0000 + 32'(i);
      PRDATA_S[3*DATA_W +: DATA_W] = 32'hA5A5_1234;
      repeat (3) @(negedge PCLK);
      chk("reset_idle", {63'd0, all_idle()}, 64'd1);
      PRESET = 1'b0;

      // zero-wait read slot 3, upstream held high after completion
      wait_n = 0;
      xfer(32'h0300_0010, 1'b0, 32'h0, 3, 8'h08, 1, 32'hA5A5_1234, 1'b0, 3);
      // write slot 7 with four wait states: read data must not leak through
      wait_n = 4;
      xfer(32'h0700_0000, 1'b1, 32'hDEAD_BEEF, 7, 8'h80, 5, 32'h0, 1'b0, 0);
      wait_n = 0;
      // unmapped slots, including the first index past NSLOT
      xfer(32'h0900_0000, 1'b0, 32'h0, 1, 8'h00, 0, 32'h0, 1'b1, 0);
      xfer(32'h0800_0004, 1'b1, 32'h1234_5678, 1, 8'h00, 0, 32'h0, 1'b1, 0);
      // slave error on slot 2
      PSLVERR_S = 8'h04;
      xfer(32'h0200_0008, 1'b0, 32'h0, 3, 8'h04, 1, 32'hC0DE_0002, 1'b1, 1);
      PSLVERR_S = '0;
      xfer(32'h0000_0000, 1'b0, 32'h0, 3, 8'h01, 1, 32'hC0DE_0000, 1'b0, 0);
      wait_n = 1;
      xfer(32'h06FF_FFFC, 1'b0, 32'h0, 4, 8'h40, 2, 32'hC0DE_0006, 1'b0, 0);
      wait_n = 0;

      // reset pulsed during access
      hang = 1'b1;
      @(negedge PCLK);
      PSEL_M = 1'b1; PENABLE_M = 1'b0; PADDR_M = 32'h0500_0000; PWRITE_M = 1'b1; PWDATA_M = 32'hFACE_0001;
      @(negedge PCLK); PENABLE_M = 1'b1;
      @(negedge PCLK);
      chk("in_access_before_reset", {55'd0, PENABLE_S, PSEL_S}, {55'd0, 1'b1, 8'h20});
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("reset_mid_access_idle", {63'd0, all_idle()}, 64'd1);
      PRESET = 1'b0; PSEL_M = 1'b0; PENABLE_M = 1'b0; hang = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge PCLK);
         chk("no_pready_after_abort", {63'd0, PREADY_M}, 64'd0);
      end
      xfer(32'h0500_0000, 1'b0, 32'h0, 3, 8'h20, 1, 32'hC0DE_0005, 1'b0, 0);

      // slot that never becomes ready
      hang = 1'b1;
`ifdef APB2APB_BRIDGE_TIMEOUT_EN
      xfer(32'h0400_0000, 1'b0, 32'h0, 12, 8'h10, 10, 32'h0, 1'b1, 1);
`else
      @(negedge PCLK);
      PSEL_M = 1'b1; PENABLE_M = 1'b0; PADDR_M = 32'h0400_0000; PWRITE_M = 1'b0;
      @(negedge PCLK); PENABLE_M = 1'b1;
      repeat (1000) @(negedge PCLK);
      chk("still_waiting", {54'd0, PREADY_M, PENABLE_S, PSEL_S}, {54'd0, 1'b0, 1'b1, 8'h10});
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0; PSEL_M = 1'b0; PENABLE_M = 1'b0;
      @(negedge PCLK);
      chk("recovered_idle", {63'd0, all_idle()}, 64'd1);
`endif
      hang = 1'b0;
      xfer(32'h0100_0000, 1'b1, 32'h0000_00FF, 3, 8'h02, 1, 32'h0, 1'b0, 0);

      repeat (3) @(negedge PCLK);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb2apb_bridge.md
APB2APB_BRIDGE -- requirements
Module: apb2apb_bridge

Interface
REQ-001 SHALL have parameters: NSLOT, default 16, number of downstream slots (1..16); ADDR_W, default 32, address width; DATA_W, default 32, data width; SEL_LSB, default 24, LSB of the 4-bit slot-decode field in the address; TIMEOUT, default 255, downstream access-phase cycle limit.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high:
  PCLK  in  1  clock for both APB sides
  PRESET  in  1  synchronous active-high reset
  PSEL_M  in  1  upstream select
  PENABLE_M  in  1  upstream enable
  PADDR_M  in  ADDR_W  upstream address
  PWRITE_M  in  1  upstream write
  PWDATA_M  in  DATA_W  upstream write data
  PRDATA_M  out  DATA_W  upstream read data
  PREADY_M  out  1  upstream ready
  PSLVERR_M  out  1  upstream error
  PSEL_S  out  NSLOT  one-hot downstream selects
  PENABLE_S, PWRITE_S  out  1  downstream enable, write
  PADDR_S  out  ADDR_W  downstream address
  PWDATA_S  out  DATA_W  downstream write data
  PRDATA_S  in  NSLOT*DATA_W  packed read data, slot i at [i*DATA_W +: DATA_W]
  PREADY_S, PSLVERR_S  in  NSLOT  per-slot ready, error

Function
REQ-003 SHALL run FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-004 IDLE: on PSEL_M=1 and PENABLE_M=0, SHALL capture PADDR_M, PWRITE_M, PWDATA_M and slot = PADDR_M[SEL_LSB+3:SEL_LSB]; go to SETUP, or to RESP with error if slot >= NSLOT.
REQ-005 SETUP: PSEL_S[slot]=1, PENABLE_S=0; next cycle ACCESS.
REQ-006 ACCESS: PSEL_S[slot]=1, PENABLE_S=1; stay until PREADY_S[slot]=1, then latch PRDATA_S slot slice and PSLVERR_S[slot], go to RESP.
REQ-007 RESP: PREADY_M=1 for exactly one cycle with latched PRDATA_M/PSLVERR_M; all downstream outputs idle; next IDLE.
REQ-008 Outside RESP, PREADY_M=0, PSLVERR_M=0, PRDATA_M=0.
REQ-009 Downstream PADDR_S/PWRITE_S/PWDATA_S SHALL be registered and held stable SETUP through ACCESS; all zero otherwise.
REQ-010 Zero-wait slave: upstream setup at cycle T, PREADY_M high at T+3.
REQ-011 Unmapped slot: no downstream PSEL asserted; PREADY_M=1, PSLVERR_M=1, PRDATA_M=0 at T+1.
REQ-012 Writes SHALL return PRDATA_M=0.
REQ-013 Upstream inputs other than the IDLE capture SHALL be ignored; PSEL_M held through RESP SHALL NOT start a new transfer until IDLE sees a fresh setup phase.
REQ-014 PSEL_S SHALL be one-hot or zero in every cycle.

Reset
REQ-015 PRESET=1 at any clock edge, including mid-transfer, SHALL force IDLE and zero all outputs and captured registers next cycle; an aborted transfer produces no PREADY_M.

Configuration
REQ-016 With APB2APB_BRIDGE_TIMEOUT_EN defined: 8-bit counter clears on entry to ACCESS, increments each ACCESS cycle; at count == TIMEOUT without PREADY_S[slot], abort to RESP with PSLVERR_M=1, PRDATA_M=0.
REQ-017 Without APB2APB_BRIDGE_TIMEOUT_EN: no counter; ACCESS waits indefinitely; TIMEOUT unused.

Structure
REQ-018 Shared package apb_bridge_pkg SHALL hold the FSM state enum, the 4-bit slot-field width constant and the default parameter values.
REQ-019 Sub-module apb_slot_decode SHALL produce one-hot select and an unmapped flag from slot index and NSLOT.

Verification
REQ-020 Read, addr 0x0300_0010, slot 3 PREADY_S=1, PRDATA=0xA5A5_1234 -> PSEL_S=0x0008, PREADY_M at T+3, PRDATA_M=0xA5A5_1234, PSLVERR_M=0.
REQ-021 Write 0xDEAD_BEEF to 0x0700_0000, slot 7 holds PREADY_S low 4 cycles -> PWDATA_S stable 5 ACCESS cycles, PREADY_M at T+7, PRDATA_M=0.
REQ-022 NSLOT=4, addr 0x0900_0000 -> no PSEL_S, PREADY_M=1, PSLVERR_M=1 at T+1.
REQ-023 Slot 2 returns PSLVERR_S=1 -> PSLVERR_M=1 in RESP cycle only.
REQ-024 TIMEOUT_EN, TIMEOUT=10, slot never ready -> PSEL_S drops, PSLVERR_M=1 after 10 ACCESS cycles; without macro, still waiting after 1000 cycles.
REQ-025 PRESET pulsed during ACCESS -> all outputs 0 next cycle, no PREADY_M, next transfer completes normally.
